cache_mem_slave: RTL and testbench

//  Avalon-MM-style pipelined memory responder (slave end of the bus driven by cache_arb m0/m1).

---
 rtl/cache_mem_slave_if.sv | 24 ++
 rtl/cache_mem_slave.sv | 87 ++++++++
 tb/tb_cache_mem_slave.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_slave_if.sv
// Avalon-MM-style pipelined bus between a master (cache_arb m0/m1) and cache_mem_slave.
interface cache_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_address;
  logic [DATA_WIDTH/8-1:0] s_byteEnable;
  logic                    s_read;
  logic                    s_write;
  logic [DATA_WIDTH-1:0]   s_writeData;
  logic                    s_waitRequest;
  logic [DATA_WIDTH-1:0]   s_readData;
  logic                    s_readDataValid;

  modport master (
    output s_address, s_byteEnable, s_read, s_write, s_writeData,
    input  s_waitRequest, s_readData, s_readDataValid
  );

  modport slave (
    input  s_address, s_byteEnable, s_read, s_write, s_writeData,
    output s_waitRequest, s_readData, s_readDataValid
  );
endinterface

// File: rtl/cache_mem_slave.sv
// Pipelined word RAM responder: byte-enable writes, fixed-latency in-order reads, bounded pending reads.
// Optional random stall injection when WAIT_INJECT_EN is defined.
module cache_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic             clk,
  input  logic             rest,
  cache_mem_slave_if.slave bus
);
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  logic [DATA_WIDTH-1:0]                 mem [MEM_DEPTH];
  logic [IDX_W-1:0]                      idx;
  logic                                  rest_sync_done;
  logic [PEND_W-1:0]                     pending;
  logic [RD_LATENCY-1:0]                 vld_pipe, vld_in;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_pipe, dat_in;
  logic                                  stall, inject, wr_acc, rd_acc;
  logic                                  unused_addr;

  // Upper and sub-word address bits alias onto the same word.
  assign idx         = bus.s_address[IDX_W+1:2];
  assign unused_addr = ^{bus.s_address[ADDR_WIDTH-1:IDX_W+2], bus.s_address[1:0]};

`ifdef WAIT_INJECT_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign inject = lfsr[0];
`else
  assign inject = 1'b0;
`endif

  // Stall comes only from registered state; a returning read frees a slot next cycle.
  assign stall  = !rest_sync_done | (pending == PEND_W'(MAX_PENDING)) | inject;
  assign wr_acc = bus.s_write & !stall;
  assign rd_acc = bus.s_read & !bus.s_write & !stall;

  assign bus.s_waitRequest   = stall;
  assign bus.s_readDataValid = vld_pipe[RD_LATENCY-1];
  assign bus.s_readData      = dat_pipe[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (wr_acc)
      for (int i = 0; i < BE_W; i++)
        if (bus.s_byteEnable[i]) mem[idx][i*8 +: 8] <= bus.s_writeData[i*8 +: 8];
  end

  always_comb begin
    vld_in    = '0;
    dat_in    = '0;
    vld_in[0] = rd_acc;
    dat_in[0] = mem[idx];
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_in[i] = vld_pipe[i-1];
      dat_in[i] = dat_pipe[i-1];
    end
  end

  // Data stages only load alongside a valid, so the output stage holds its last result.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      rest_sync_done <= 1'b0;
      pending        <= '0;
      vld_pipe       <= '0;
      dat_pipe       <= '0;
    end else begin
      rest_sync_done <= 1'b1;
      vld_pipe       <= vld_in;
      for (int i = 0; i < RD_LATENCY; i++)
        if (vld_in[i]) dat_pipe[i] <= dat_in[i];
      case ({rd_acc, vld_pipe[RD_LATENCY-1]})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_slave.sv
// Randomized self-checking bench for cache_mem_slave against a word-array/queue reference model.
module tb_cache_mem_slave;
  localparam int LA = 2, PA = 4;
  localparam int LB = 4, PB = 2;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic clk  = 1'b0;
  logic rest = 1'b1;
  int   checks = 0, failures = 0, cyc = 0;
  logic [31:0] mem_a [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_mem_slave_if bus_a ();
  cache_mem_slave_if bus_b ();

  cache_mem_slave #(.RD_LATENCY(LA), .MAX_PENDING(PA)) dut_a (.clk(clk), .rest(rest), .bus(bus_a));
  cache_mem_slave #(.RD_LATENCY(LB), .MAX_PENDING(PB)) dut_b (.clk(clk), .rest(rest), .bus(bus_b));

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Present one request on bus A until accepted; e = edge index of the accept (-1 on timeout).
  task automatic a_issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int e);
    bit w;
    logic [31:0] t;
    e = -1;
    @(negedge clk);
    bus_a.s_read = rd; bus_a.s_write = wr; bus_a.s_address = addr;
    bus_a.s_writeData = data; bus_a.s_byteEnable = be;
    for (int k = 0; k < 64; k++) begin
      w = bus_a.s_waitRequest;
      @(posedge clk);
      if (!w) begin e = cyc; break; end
      @(negedge clk);
    end
    #1;
    bus_a.s_read = 1'b0; bus_a.s_write = 1'b0;
    if (e >= 0 && wr) begin
      t = mem_a.exists(widx(addr)) ? mem_a[widx(addr)] : 32'hx;
      for (int i = 0; i < 4; i++) if (be[i]) t[i*8 +: 8] = data[i*8 +: 8];
      mem_a[widx(addr)] = t;
    end
  endtask

  task automatic a_wait_valid(output int c, output logic [31:0] d);
    c = -1; d = 'x;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus_a.s_readDataValid) begin c = cyc; d = bus_a.s_readData; break; end
    end
  endtask

  task automatic test_reset;
    #2 rest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus_a.s_waitRequest !== 1'b1) begin failures++; $display("FAIL reset_wait got=%b exp=1", bus_a.s_waitRequest); end
    checks++; if (bus_a.s_readDataValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_a.s_readDataValid); end
    checks++; if (bus_a.s_readData !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus_a.s_readData); end
    checks++; if (bus_b.s_waitRequest !== 1'b1) begin failures++; $display("FAIL reset_wait_b got=%b exp=1", bus_b.s_waitRequest); end
    rest = 1'b1;
    @(negedge clk);
`ifndef WAIT_INJECT_EN
    checks++; if (bus_a.s_waitRequest !== 1'b0) begin failures++; $display("FAIL release_wait got=%b exp=0", bus_a.s_waitRequest); end
`endif
  endtask

  task automatic test_basic;
    int e, c;
    logic [31:0] d;
    a_issue(0, 1, 32'h10, 32'h12345678, 4'hF, e);
    a_issue(1, 0, 32'h10, 32'h0, 4'h0, e);
    a_wait_valid(c, d);
    checks++; if (e < 0 || c !== e + LA) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", c, e + LA); end
    checks++; if (d !== 32'h12345678) begin failures++; $display("FAIL basic_data got=%h exp=12345678", d); end
    @(negedge clk);
    checks++; if (bus_a.s_readDataValid !== 1'b0) begin failures++; $display("FAIL basic_single_valid got=%b exp=0", bus_a.s_readDataValid); end
    checks++; if (bus_a.s_readData !== 32'h12345678) begin failures++; $display("FAIL basic_hold got=%h exp=12345678", bus_a.s_readData); end
    a_issue(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, e);
    a_issue(1, 0, 32'h10, 32'h0, 4'h0, e);
    a_wait_valid(c, d);
    checks++; if (e < 0 || c !== e + LA) begin failures++; $display("FAIL be_latency got=%0d exp=%0d", c, e + LA); end
    checks++; if (d !== 32'h12BB56DD) begin failures++; $display("FAIL be_data got=%h exp=12bb56dd", d); end
  endtask

  task automatic test_alias;
    int e, c;
    logic [31:0] d;
    a_issue(0, 1, 32'h1000, 32'hCAFEF00D, 4'hF, e);
    a_issue(1, 0, 32'h0, 32'h0, 4'h0, e);
    a_wait_valid(c, d);
    checks++; if (e < 0 || c !== e + LA) begin failures++; $display("FAIL alias_latency got=%0d exp=%0d", c, e + LA); end
    checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL alias_data got=%h exp=cafef00d", d); end
  endtask

  task automatic test_rw_both;
    int e, c, nv;
    logic [31:0] d;
    nv = 0;
    a_issue(1, 1, 32'h20, 32'h5A5A5A5A, 4'hF, e);
    for (int k = 0; k < LA + 3; k++) begin
      @(negedge clk);
      if (bus_a.s_readDataValid) nv++;
    end
    checks++; if (e < 0 || nv != 0) begin failures++; $display("FAIL rw_no_valid got=%0d exp=0 (accept=%0d)", nv, e); end
    a_issue(1, 0, 32'h20, 32'h0, 4'h0, e);
    a_wait_valid(c, d);
    checks++; if (d !== 32'h5A5A5A5A) begin failures++; $display("FAIL rw_data got=%h exp=5a5a5a5a", d); end
  endtask

  task automatic test_pending;
    logic [31:0] wd [4];
    bit   wseq [$];
    bit   w;
    int   nxt, got, start, first_v;
    nxt = 0; got = 0; start = -1; first_v = -1;
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    for (int k = 0; k < 300 && got < 4; k++) begin
      @(negedge clk);
      if (bus_b.s_readDataValid) begin
        if (first_v < 0) first_v = k;
        checks++;
        if (got >= 4 || bus_b.s_readData !== wd[got & 3]) begin
          failures++; $display("FAIL pend_order idx=%0d got=%h exp=%h", got, bus_b.s_readData, wd[got & 3]);
        end
        got++;
      end
      bus_b.s_byteEnable = 4'hF;
      bus_b.s_write      = (nxt < 4);
      bus_b.s_read       = (nxt >= 4 && nxt < 8);
      bus_b.s_address    = 32'((nxt & 3) * 4);
      bus_b.s_writeData  = wd[nxt & 3];
      w = bus_b.s_waitRequest;
      if (nxt == 4 && start < 0) start = k;
      if (start >= 0 && wseq.size() < 6) wseq.push_back(w);
      @(posedge clk);
      if (nxt < 8 && !w) nxt++;
    end
    #1 bus_b.s_read = 1'b0; bus_b.s_write = 1'b0;
    checks++; if (got != 4) begin failures++; $display("FAIL pend_count got=%0d exp=4", got); end
`ifndef WAIT_INJECT_EN
    checks++;
    if (wseq.size() != 6 || wseq[0] || wseq[1] || !wseq[2] || !wseq[3] || !wseq[4] || wseq[5]) begin
      failures++; $display("FAIL pend_wait_pattern got=%p exp=0,0,1,1,1,0", wseq);
    end
    checks++; if (first_v - start != LB) begin failures++; $display("FAIL pend_latency got=%0d exp=%0d", first_v - start, LB); end
`endif
  endtask

  task automatic test_reset_mid;
    int e, nv;
    nv = 0;
    a_issue(1, 0, 32'h10, 32'h0, 4'h0, e);
    @(negedge clk);
    rest = 1'b0;
    #1;
    checks++; if (bus_a.s_readDataValid !== 1'b0 || bus_a.s_readData !== 32'h0) begin
      failures++; $display("FAIL midrst_outputs got=%b/%h exp=0/0", bus_a.s_readDataValid, bus_a.s_readData);
    end
    checks++; if (bus_a.s_waitRequest !== 1'b1) begin failures++; $display("FAIL midrst_wait got=%b exp=1", bus_a.s_waitRequest); end
    @(negedge clk);
    rest = 1'b1;
    for (int k = 0; k < LA + 4; k++) begin
      @(negedge clk);
`ifndef WAIT_INJECT_EN
      if (k == 0) begin
        checks++; if (bus_a.s_waitRequest !== 1'b0) begin failures++; $display("FAIL midrst_release_wait got=%b exp=0", bus_a.s_waitRequest); end
      end
`endif
      if (bus_a.s_readDataValid) nv++;
    end
    checks++; if (e < 0 || nv != 0) begin failures++; $display("FAIL midrst_discard got=%0d exp=0 (accept=%0d)", nv, e); end
  endtask

  task automatic test_random;
    exp_t q [$];
    exp_t x;
    bit   done;
    int   to;
    logic [31:0] last;
    done = 0; to = 0; last = 32'h0;
    for (int i = 0; i < 16; i++) begin
      int e;
      a_issue(0, 1, 32'h100 + 32'(i * 4), $urandom, 4'hF, e);
      if (e < 0) to++;
    end
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          int e, kind;
          bit rd, wr;
          logic [31:0] addr;
          kind = $urandom_range(0, 9);
          rd   = (kind < 5) || (kind == 9);
          wr   = (kind >= 5);
          addr = ($urandom & 32'hFFFF_F000) | 32'h100 | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
          a_issue(rd, wr, addr, $urandom, 4'($urandom), e);
          if (e < 0) to++;
          else if (rd && !wr) begin
            x.d = mem_a[widx(addr)]; x.due = e + LA; q.push_back(x);
          end
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        done = 1;
      end
      begin
        for (int k = 0; k < 20000 && !(done && q.size() == 0); k++) begin
          @(negedge clk);
          if (q.size() == PA) begin
            checks++; if (bus_a.s_waitRequest !== 1'b1) begin failures++; $display("FAIL rnd_limit_wait cyc=%0d got=%b exp=1", cyc, bus_a.s_waitRequest); end
          end
`ifndef WAIT_INJECT_EN
          else begin
            checks++; if (bus_a.s_waitRequest !== 1'b0) begin failures++; $display("FAIL rnd_free_wait cyc=%0d got=%b exp=0 pend=%0d", cyc, bus_a.s_waitRequest, q.size()); end
          end
`endif
          if (bus_a.s_readDataValid) begin
            checks++;
            if (q.size() == 0) begin
              failures++; $display("FAIL rnd_spurious_valid cyc=%0d got=1 exp=0", cyc);
            end else begin
              x = q.pop_front();
              if (bus_a.s_readData !== x.d || cyc != x.due) begin
                failures++; $display("FAIL rnd_read got=%h@%0d exp=%h@%0d", bus_a.s_readData, cyc, x.d, x.due);
              end
              last = x.d;
            end
          end else begin
            checks++; if (bus_a.s_readData !== last) begin failures++; $display("FAIL rnd_hold got=%h exp=%h", bus_a.s_readData, last); end
          end
        end
      end
    join
    checks++; if (to != 0 || q.size() != 0 || !done) begin
      failures++; $display("FAIL rnd_complete got=timeouts:%0d left:%0d exp=0/0", to, q.size());
    end
  endtask

  initial begin
    bus_a.s_read = 1'b0; bus_a.s_write = 1'b0; bus_a.s_address = '0; bus_a.s_writeData = '0; bus_a.s_byteEnable = '0;
    bus_b.s_read = 1'b0; bus_b.s_write = 1'b0; bus_b.s_address = '0; bus_b.s_writeData = '0; bus_b.s_byteEnable = '0;
    test_reset;
    test_basic;
    test_alias;
    test_rw_both;
    test_pending;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
